result_presenter: RTL and testbench



---
 rtl/result_presenter.sv | 166 ++++++++++++++++
 tb/tb_result_presenter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/result_presenter.sv
// Presents a captured result on the LEDs one CW-bit word at a time, most significant word first.
// Optional auto-advance tick counter: define RESULT_PRESENTER_AUTOADV_EN.
module result_presenter #(
  parameter int DW         = 64,
  parameter int CW         = 16,
  parameter int AUTO_TICKS = 50_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          res_valid,
  input  logic [DW-1:0] res_data,
  input  logic [1:0]    res_size,
  output logic          res_ready,
  input  logic          step,
  output logic [CW-1:0] leds,
  output logic [1:0]    chunk_idx,
  output logic          sign,
  output logic          busy,
  output logic          done
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHOW = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic [CW-1:0] leds_q, leds_d;
  logic [1:0]    idx_q, idx_d;
  logic          sign_q, sign_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic [1:0]    last_s;
  logic          adv_s;

  function automatic logic [CW-1:0] chunk_sel(input logic [DW-1:0] d, input logic [1:0] idx);
    case (idx)
      2'd0:    chunk_sel = d[CW-1:0];
      2'd1:    chunk_sel = d[2*CW-1:CW];
      2'd2:    chunk_sel = d[3*CW-1:2*CW];
      2'd3:    chunk_sel = d[4*CW-1:3*CW];
      default: chunk_sel = d[CW-1:0];
    endcase
  endfunction

  function automatic logic msb_at(input logic [DW-1:0] d, input logic [1:0] last);
    case (last)
      2'd0:    msb_at = d[CW-1];
      2'd1:    msb_at = d[2*CW-1];
      default: msb_at = d[4*CW-1];
    endcase
  endfunction

  // Size code 3 is treated as a full 64-bit result.
  always_comb begin
    case (res_size)
      2'd0:    last_s = 2'd0;
      2'd1:    last_s = 2'd1;
      default: last_s = 2'd3;
    endcase
  end

`ifdef RESULT_PRESENTER_AUTOADV_EN
  localparam int TW = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
  localparam logic [TW-1:0] TERM = TW'(AUTO_TICKS - 1);
  logic [TW-1:0] tick_q, tick_d;

  // A manual step and the terminal count together still advance only once.
  assign adv_s = step | (tick_q == TERM);

  always_comb begin
    tick_d = tick_q;
    if (state_q == S_SHOW && !adv_s) begin
      tick_d = tick_q + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      tick_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end
`else
  assign adv_s = step;
`endif

  always_comb begin
    state_d = state_q;
    rdat_d  = rdat_q;
    leds_d  = leds_q;
    idx_d   = idx_q;
    sign_d  = sign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    case (state_q)
      S_IDLE: begin
        // A step coinciding with capture is dropped so the first chunk is always shown.
        if (res_valid && ready_q) begin
          rdat_d  = res_data;
          idx_d   = last_s;
          leds_d  = chunk_sel(res_data, last_s);
          sign_d  = msb_at(res_data, last_s);
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = S_SHOW;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_SHOW: begin
        if (adv_s) begin
          if (idx_q != 2'd0) begin
            idx_d  = idx_q - 2'd1;
            leds_d = chunk_sel(rdat_q, idx_q - 2'd1);
          end else begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdat_q  <= '0;
      leds_q  <= '0;
      idx_q   <= 2'd0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rdat_q  <= rdat_d;
      leds_q  <= leds_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign res_ready = ready_q;
  assign leds      = leds_q;
  assign chunk_idx = idx_q;
  assign sign      = sign_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_result_presenter.sv
// Directed bench for result_presenter; auto-advance section runs only with RESULT_PRESENTER_AUTOADV_EN.
module tb_result_presenter;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [63:0] res_data;
  logic [1:0]  res_size;
  logic        res_ready;
  logic        step;
  logic [15:0] leds;
  logic [1:0]  chunk_idx;
  logic        sign;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  result_presenter #(.DW(64), .CW(16), .AUTO_TICKS(4)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .res_size(res_size), .res_ready(res_ready), .step(step), .leds(leds),
    .chunk_idx(chunk_idx), .sign(sign), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] e_leds, input logic [1:0] e_idx,
                         input logic e_sign, input logic e_busy, input logic e_done,
                         input logic e_ready);
    chk({tag, ".leds"},  {48'd0, leds},      {48'd0, e_leds});
    chk({tag, ".idx"},   {62'd0, chunk_idx}, {62'd0, e_idx});
    chk({tag, ".sign"},  {63'd0, sign},      {63'd0, e_sign});
    chk({tag, ".busy"},  {63'd0, busy},      {63'd0, e_busy});
    chk({tag, ".done"},  {63'd0, done},      {63'd0, e_done});
    chk({tag, ".ready"}, {63'd0, res_ready}, {63'd0, e_ready});
  endtask

  initial begin
    rst = 1'b1; res_valid = 1'b0; res_data = 64'd0; res_size = 2'd0; step = 1'b0;
    tick(); tick();
    chk_out("reset", 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    tick();

    // Reset during a 64-bit presentation at chunk 2
    res_valid = 1'b1; res_data = 64'h1234_5678_9ABC_DEF0; res_size = 2'd2;
    tick();
    res_valid = 1'b0;
    chk_out("mid.cap", 16'h1234, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step = 1'b1; tick(); step = 1'b0;
    chk_out("mid.s1", 16'h5678, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1; #1;
    chk_out("mid.rst", 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); rst = 1'b0; tick();
    chk_out("mid.idle", 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full 64-bit walk
    res_valid = 1'b1; res_data = 64'h1234_5678_9ABC_DEF0; res_size = 2'd2;
    tick();
    res_valid = 1'b0;
    chk_out("w64.c3", 16'h1234, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step = 1'b1; tick();
    chk_out("w64.c2", 16'h5678, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("w64.c1", 16'h9ABC, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); step = 1'b0;
    chk_out("w64.c0", 16'hDEF0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("w64.hold", 16'hDEF0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step = 1'b1; tick(); step = 1'b0;
    chk_out("w64.done", 16'hDEF0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("w64.after", 16'hDEF0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Step in IDLE is ignored
    step = 1'b1; tick(); step = 1'b0;
    chk_out("idle.step", 16'hDEF0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 16-bit result, negative
    res_valid = 1'b1; res_data = 64'h0000_0000_0000_8001; res_size = 2'd0;
    tick();
    res_valid = 1'b0;
    chk_out("w16.c0", 16'h8001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step = 1'b1; tick(); step = 1'b0;
    chk_out("w16.done", 16'h8001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // 32-bit, valid held and coincident with step at capture
    res_valid = 1'b1; res_data = 64'hFFFF_FFFF_8000_0007; res_size = 2'd1; step = 1'b1;
    tick(); step = 1'b0;
    chk_out("w32.c1", 16'h8000, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    res_data = 64'h0000_0000_0000_1111; res_size = 2'd0;
    tick();
    chk_out("w32.hold", 16'h8000, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    step = 1'b1; tick(); step = 1'b0;
    chk_out("w32.c0", 16'h0007, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step = 1'b1; tick(); step = 1'b0;
    chk_out("w32.done", 16'h0007, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("w32.recap", 16'h1111, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    res_valid = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    chk_out("w32.redone", 16'h1111, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();

    // Size code 3 behaves like 64-bit
    res_valid = 1'b1; res_data = 64'hC000_0000_0000_0000; res_size = 2'd3;
    tick();
    res_valid = 1'b0;
    chk_out("sz3.c3", 16'hC000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step = 1'b1; tick(); tick(); tick(); tick(); step = 1'b0;
    chk_out("sz3.done", 16'h0000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();

`ifdef RESULT_PRESENTER_AUTOADV_EN
    res_valid = 1'b1; res_data = 64'h0000_0000_AAAA_5555; res_size = 2'd1;
    tick();
    res_valid = 1'b0;
    chk_out("auto.c1a", 16'hAAAA, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_out("auto.c1d", 16'hAAAA, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("auto.c0a", 16'h5555, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_out("auto.c0d", 16'h5555, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("auto.done", 16'h5555, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();

    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    tick(); tick();
    step = 1'b1; tick(); step = 1'b0;
    chk_out("auto.early", 16'h5555, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_out("auto.restart", 16'h5555, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("auto.done2", 16'h5555, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
